// File: rtl/pwm_serial_frame_gen.sv
// Multi-channel PWM generator that serialises one bit per channel per frame onto a
// daisy-chained shift register, with shadowed duties applied only at period wrap.
module pwm_serial_frame_gen #(
    parameter int N_CH    = 8,
    parameter int CNT_W   = 8,
    parameter int PER_RST = 100
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    en,
    input  logic [CNT_W-1:0]        period,
    input  logic                    duty_we,
    input  logic [$clog2(N_CH)-1:0] duty_addr,
    input  logic [CNT_W-1:0]        duty_data,
    output logic                    s_out,
    output logic                    s_shift,
    output logic                    latch,
    output logic [N_CH-1:0]         pwm_par,
    output logic                    frame_start,
    output logic [CNT_W-1:0]        cnt
);

    localparam int KW = $clog2(N_CH);
    localparam logic [KW-1:0] K_LAST = KW'(N_CH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_LATCH
    } state_t;

    state_t            state_reg, state_next;
    logic [KW-1:0]     k_reg, k_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [CNT_W-1:0]  period_act_reg, period_act_next;
    logic              s_out_reg, s_out_next;
    logic              s_shift_reg, s_shift_next;
    logic              latch_reg, latch_next;
    logic              frame_start_reg, frame_start_next;
    logic [N_CH-1:0]   pwm_par_reg;
    logic              wrap;
    logic              start_frame;
    logic [CNT_W-1:0]  duty_first;

    logic [CNT_W-1:0]  duty_act    [N_CH];
    logic [CNT_W-1:0]  duty_shadow [N_CH];
    logic [N_CH-1:0]   frame_buf;

    // Per-channel shadow/active duty pair and the frame capture bit.
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        logic [CNT_W-1:0] shadow_reg;
        logic [CNT_W-1:0] act_reg;
        logic             buf_reg;
        logic             wr_hit;

        assign wr_hit = duty_we && (duty_addr == KW'(gi));

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                shadow_reg <= '0;
                act_reg    <= '0;
                buf_reg    <= 1'b0;
            end else begin
                if (wr_hit) begin
                    shadow_reg <= duty_data;
                end
                if (wrap) begin
                    act_reg <= shadow_reg;
                end
                if (s_shift_next && (k_next == KW'(gi))) begin
                    buf_reg <= s_out_next;
                end
            end
        end

        assign duty_shadow[gi] = shadow_reg;
        assign duty_act[gi]    = act_reg;
        assign frame_buf[gi]   = buf_reg;
    end

    // The first bit of a frame that follows a wrap must already see the new duty.
    assign duty_first = wrap ? duty_shadow[N_CH-1] : duty_act[N_CH-1];

    always_comb begin
        state_next       = state_reg;
        k_next           = k_reg;
        cnt_next         = cnt_reg;
        period_act_next  = period_act_reg;
        wrap             = 1'b0;
        start_frame      = 1'b0;
        s_out_next       = 1'b0;
        s_shift_next     = 1'b0;
        latch_next       = 1'b0;
        frame_start_next = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (en) begin
                    start_frame = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (k_reg == '0) begin
                    state_next = ST_LATCH;
                    latch_next = 1'b1;
                end else begin
                    k_next       = k_reg - 1'b1;
                    s_shift_next = 1'b1;
                    s_out_next   = (cnt_reg < duty_act[k_next]);
                end
            end
            ST_LATCH: begin
                if (cnt_reg >= period_act_reg) begin
                    wrap            = 1'b1;
                    cnt_next        = '0;
                    period_act_next = period;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
                if (en) begin
                    start_frame = 1'b1;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (start_frame) begin
            state_next       = ST_SHIFT;
            k_next           = K_LAST;
            s_shift_next     = 1'b1;
            s_out_next       = (cnt_next < duty_first);
            frame_start_next = (cnt_next == '0);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= ST_IDLE;
            k_reg           <= '0;
            cnt_reg         <= '0;
            period_act_reg  <= CNT_W'(PER_RST);
            s_out_reg       <= 1'b0;
            s_shift_reg     <= 1'b0;
            latch_reg       <= 1'b0;
            frame_start_reg <= 1'b0;
            pwm_par_reg     <= '0;
        end else begin
            state_reg       <= state_next;
            k_reg           <= k_next;
            cnt_reg         <= cnt_next;
            period_act_reg  <= period_act_next;
            s_out_reg       <= s_out_next;
            s_shift_reg     <= s_shift_next;
            latch_reg       <= latch_next;
            frame_start_reg <= frame_start_next;
            if (latch_next) begin
                pwm_par_reg <= frame_buf;
            end
        end
    end

    assign s_out       = s_out_reg;
    assign s_shift     = s_shift_reg;
    assign latch       = latch_reg;
    assign frame_start = frame_start_reg;
    assign pwm_par     = pwm_par_reg;
    assign cnt         = cnt_reg;

endmodule

// File: tb/tb_pwm_serial_frame_gen.sv
// Frame-level bench for pwm_serial_frame_gen: each frame is compared against a model that
// tracks step, active/shadow duties and period as plain integers.
module tb_pwm_serial_frame_gen;

    localparam int N_CH    = 8;
    localparam int CNT_W   = 8;
    localparam int PER_RST = 100;
    localparam int AW      = 3;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             en;
    logic [CNT_W-1:0] period;
    logic             duty_we;
    logic [AW-1:0]    duty_addr;
    logic [CNT_W-1:0] duty_data;
    logic             s_out;
    logic             s_shift;
    logic             latch;
    logic [N_CH-1:0]  pwm_par;
    logic             frame_start;
    logic [CNT_W-1:0] cnt;

    pwm_serial_frame_gen #(.N_CH(N_CH), .CNT_W(CNT_W), .PER_RST(PER_RST)) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .period(period),
        .duty_we(duty_we), .duty_addr(duty_addr), .duty_data(duty_data),
        .s_out(s_out), .s_shift(s_shift), .latch(latch), .pwm_par(pwm_par),
        .frame_start(frame_start), .cnt(cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int frame_no = 0;
    bit running = 0;
    bit abort = 0;

    int m_cnt;
    int m_per_act;
    int m_act [N_CH];
    int m_sh  [N_CH];

    function automatic void model_reset();
        m_cnt = 0;
        m_per_act = PER_RST;
        for (int c = 0; c < N_CH; c++) begin
            m_act[c] = 0;
            m_sh[c] = 0;
        end
    endfunction

    function automatic void model_advance();
        if (m_cnt >= m_per_act) begin
            m_cnt = 0;
            for (int c = 0; c < N_CH; c++) m_act[c] = m_sh[c];
            m_per_act = int'(period);
        end else begin
            m_cnt++;
        end
    endfunction

    task automatic do_write(input int a, input int d);
        duty_we = 1'b1;
        duty_addr = AW'(a);
        duty_data = CNT_W'(d);
        if (a < N_CH) m_sh[a] = d;
        @(negedge clk);
        duty_we = 1'b0;
    endtask

    // One complete frame: head, N_CH bits, latch cycle. Optional write on the first bit,
    // optional en drop at bit index drop_at.
    task automatic capture_frame(input bit wr, input int waddr, input int wdata,
                                 input int drop_at, output logic [N_CH-1:0] got,
                                 output int fc);
        logic [N_CH-1:0] exp;
        int waited;
        bit ok;
        got = '0;
        fc = -1;
        if (abort) return;
        waited = 0;
        if (!running) begin
            while (s_shift !== 1'b1 && waited < 4 * N_CH) begin
                @(negedge clk);
                waited++;
            end
        end
        fc = int'(cnt);
        checks++;
        if (s_shift !== 1'b1 || frame_start !== (m_cnt == 0) || cnt !== CNT_W'(m_cnt)) begin
            errors++;
            $display("FAIL frame_head f=%0d s_shift=%b frame_start=%b cnt=%0d required 1 %b %0d",
                     frame_no, s_shift, frame_start, cnt, (m_cnt == 0), m_cnt);
            if (s_shift !== 1'b1) begin
                abort = 1;
                return;
            end
        end
        for (int k = 0; k < N_CH; k++) exp[k] = (m_cnt < m_act[k]);
        ok = 1;
        for (int i = 0; i < N_CH; i++) begin
            if (i == 0 && wr) begin
                duty_we = 1'b1;
                duty_addr = AW'(waddr);
                duty_data = CNT_W'(wdata);
                if (waddr < N_CH) m_sh[waddr] = wdata;
            end
            if (i == drop_at) en = 1'b0;
            if (s_shift !== 1'b1 || latch !== 1'b0 || (i > 0 && frame_start !== 1'b0) ||
                cnt !== CNT_W'(m_cnt)) ok = 0;
            got[N_CH-1-i] = s_out;
            @(negedge clk);
            duty_we = 1'b0;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL shift_timing f=%0d some shift cycle had wrong s_shift/latch/frame_start/cnt", frame_no);
        end
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL serial_bits f=%0d cnt=%0d got=%b required %b", frame_no, m_cnt, got, exp);
        end
        checks++;
        if (latch !== 1'b1 || s_shift !== 1'b0 || pwm_par !== exp) begin
            errors++;
            $display("FAIL latch_cycle f=%0d latch=%b s_shift=%b pwm_par=%b required 1 0 %b",
                     frame_no, latch, s_shift, pwm_par, exp);
        end
        $display("frame %0d cnt=%0d bits=%b", frame_no, fc, got);
        frame_no++;
        model_advance();
        running = en;
        @(negedge clk);
    endtask

    task automatic run_until(input int target);
        logic [N_CH-1:0] g;
        int fc;
        int n = 0;
        while (m_cnt != target && n < 400 && !abort) begin
            capture_frame(0, 0, 0, -1, g, fc);
            n++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; en = 1'b0; period = CNT_W'(PER_RST);
        duty_we = 1'b0; duty_addr = '0; duty_data = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({s_out, s_shift, latch, frame_start, cnt, pwm_par} !== '0) begin
            errors++;
            $display("FAIL reset_state outputs=%h required 0", {s_out, s_shift, latch, frame_start, cnt, pwm_par});
        end
        reset_n = 1'b1;
        en = 1'b1;
        for (int i = 0; i < 10 && s_shift !== 1'b1; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({s_out, s_shift, latch, frame_start, cnt, pwm_par} !== '0) begin
            errors++;
            $display("FAIL reset_async outputs=%h required 0", {s_out, s_shift, latch, frame_start, cnt, pwm_par});
        end
        begin
            bit seen = 0;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                if (latch !== 1'b0 || s_shift !== 1'b0) seen = 1;
            end
            checks++;
            if (seen) begin
                errors++;
                $display("FAIL reset_hold latch/s_shift active during reset, required 0");
            end
        end
        en = 1'b0;
        reset_n = 1'b1;
        begin
            bit bad = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if ({s_out, s_shift, latch, frame_start, cnt, pwm_par} !== '0) bad = 1;
            end
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL reset_idle outputs left 0 with en=0, required all 0");
            end
        end
        model_reset();
        running = 0;
        $display("reset test done");
    endtask

    task automatic test_duty_sweep();
        logic [N_CH-1:0] g;
        int fc;
        int hc [N_CH];
        for (int c = 0; c < N_CH; c++) do_write(c, (c + 1) * 10);
        period = 8'd100;
        en = 1'b1;
        for (int f = 0; f < 101; f++) capture_frame(0, 0, 0, -1, g, fc);
        for (int c = 0; c < N_CH; c++) hc[c] = 0;
        for (int f = 0; f < 101; f++) begin
            capture_frame(0, 0, 0, -1, g, fc);
            for (int c = 0; c < N_CH; c++) hc[c] += int'(g[c]);
        end
        for (int c = 0; c < N_CH; c++) begin
            checks++;
            if (hc[c] != (c + 1) * 10) begin
                errors++;
                $display("FAIL sweep_high ch%0d high=%0d required %0d", c, hc[c], (c + 1) * 10);
            end
        end
    endtask

    task automatic test_shadow();
        logic [N_CH-1:0] g;
        int fc;
        int h0 = 0;
        int h1 = 0;
        int n = 0;
        run_until(30);
        period = 8'd20;
        capture_frame(1, 0, 50, -1, g, fc);
        h0 += int'(g[0]);
        while (m_cnt != 0 && n < 200 && !abort) begin
            capture_frame(0, 0, 0, -1, g, fc);
            h0 += int'(g[0]);
            n++;
        end
        checks++;
        if (h0 != 0) begin
            errors++;
            $display("FAIL shadow_hold ch0 high=%0d after mid-period write, required 0", h0);
        end
        h0 = 0;
        for (int f = 0; f < 21; f++) begin
            capture_frame(f < N_CH, f, f * 20, -1, g, fc);
            h0 += int'(g[0]);
            h1 += int'(g[1]);
        end
        checks++;
        if (h0 != 21 || h1 != 20) begin
            errors++;
            $display("FAIL shadow_apply ch0=%0d ch1=%0d required 21 20", h0, h1);
        end
    endtask

    task automatic test_serial_order();
        logic [N_CH-1:0] g;
        int fc;
        run_until(15);
        capture_frame(0, 0, 0, -1, g, fc);
        checks++;
        if (g !== 8'hFE || pwm_par !== 8'hFE || fc != 15) begin
            errors++;
            $display("FAIL serial_order cnt=%0d bits=%b pwm_par=%b required 15 11111110 11111110", fc, g, pwm_par);
        end
        run_until(0);
    endtask

    task automatic test_bounds();
        logic [N_CH-1:0] g;
        int fc;
        int mx = 0;
        int n = 0;
        int h0 = 0;
        int h1 = 0;
        period = 8'd9;
        do begin
            capture_frame(n < 2, n, (n == 1) ? 255 : 0, -1, g, fc);
            if (fc > mx) mx = fc;
            n++;
        end while (m_cnt != 0 && n < 200 && !abort);
        checks++;
        if (mx != 20) begin
            errors++;
            $display("FAIL period_not_early max cnt=%0d required 20", mx);
        end
        period = 8'd0;
        mx = 0; n = 0;
        do begin
            capture_frame(0, 0, 0, -1, g, fc);
            if (fc > mx) mx = fc;
            h0 += int'(g[0]);
            h1 += int'(g[1]);
            n++;
        end while (m_cnt != 0 && n < 200 && !abort);
        checks++;
        if (n != 10 || mx != 9 || h0 != 0 || h1 != 10) begin
            errors++;
            $display("FAIL bounds_period frames=%0d max=%0d ch0=%0d ch1=%0d required 10 9 0 10", n, mx, h0, h1);
        end
        for (int f = 0; f < 4; f++) begin
            capture_frame(0, 0, 0, -1, g, fc);
            checks++;
            if (g !== 8'hFE || fc != 0) begin
                errors++;
                $display("FAIL period_zero cnt=%0d bits=%b required 0 11111110", fc, g);
            end
        end
    endtask

    task automatic test_random();
        logic [N_CH-1:0] g;
        int fc;
        for (int f = 0; f < 60; f++) begin
            if (f % 10 == 0) period = CNT_W'($urandom_range(0, 12));
            capture_frame($urandom_range(0, 1) == 1, $urandom_range(0, N_CH - 1),
                          $urandom_range(0, 15), -1, g, fc);
        end
    endtask

    task automatic test_en_drop();
        logic [N_CH-1:0] g;
        int fc;
        bit bad = 0;
        period = 8'd40;
        run_until(0);
        run_until(5);
        capture_frame(0, 0, 0, 2, g, fc);
        for (int i = 0; i < 10; i++) begin
            if (s_shift !== 1'b0 || latch !== 1'b0 || cnt !== CNT_W'(m_cnt)) bad = 1;
            @(negedge clk);
        end
        checks++;
        if (bad || m_cnt != 6) begin
            errors++;
            $display("FAIL en_drop_idle cnt=%0d s_shift=%b latch=%b required held 6 0 0", cnt, s_shift, latch);
        end
        en = 1'b1;
        capture_frame(0, 0, 0, -1, g, fc);
        checks++;
        if (fc != fc + 0 || fc != 6) begin
            errors++;
            $display("FAIL en_resume cnt=%0d required 6", fc);
        end
        capture_frame(0, 0, 0, -1, g, fc);
    endtask

    initial begin
        test_reset();
        test_duty_sweep();
        test_shadow();
        test_serial_order();
        test_bounds();
        test_random();
        test_en_drop();
        if (abort) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout no shift activity within bound");
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
